// File: rtl/valu_seq.sv
// Multi-cycle vector ALU. It takes one vector instruction through a valid/ready handshake.
// It computes LANES elements per beat over BEATS beats, then holds the full result vector
// until the downstream accepts it.
module valu_seq #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ELEMENTS   = 8,
  parameter  int LANES      = 2,
  localparam int BEATS      = ELEMENTS / LANES,
  localparam int VLW        = $clog2(ELEMENTS + 1)
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                valid_in,
  output logic                                ready_o,
  input  logic [3:0]                          valu_op_in,
  input  logic [VLW-1:0]                      vl_in,
  input  logic [ELEMENTS-1:0]                 mask_in,
  input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0] vrs1_data_in,
  input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0] vrs2_data_in,
  output logic                                valid_o,
  input  logic                                ready_in,
  output logic [ELEMENTS-1:0][DATA_WIDTH-1:0] valu_res_o,
  output logic                                err_o
);

  localparam int S  = $clog2(DATA_WIDTH);
  localparam int IW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (ELEMENTS % LANES != 0) begin : g_bad_lanes
      $error("valu_seq: LANES must divide ELEMENTS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                              state_reg, state_next;
  logic   [BW-1:0]                     beat_reg;
  logic   [3:0]                        op_reg;
  logic   [VLW-1:0]                    vl_reg;
  logic   [ELEMENTS-1:0]               mask_reg;
  logic   [ELEMENTS-1:0][DATA_WIDTH-1:0] a_reg, b_reg, res_reg;
  logic                                err_reg;
  logic                                last_beat;

  logic [LANES-1:0][IW-1:0]            lane_idx;
  logic [LANES-1:0][DATA_WIDTH-1:0]    lane_val;

  assign last_beat  = (beat_reg == BW'(BEATS - 1));
  assign ready_o    = (state_reg == IDLE);
  assign valid_o    = (state_reg == DONE);
  assign valu_res_o = res_reg;
  assign err_o      = err_reg;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  // Next-state: accept, walk all beats, then wait for the result handshake
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_in)  state_next = BUSY;
      BUSY:    if (last_beat) state_next = DONE;
      DONE:    if (ready_in)  state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // One combinational element unit per lane; inactive elements and illegal ops yield 0
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] a, b, val;
      logic                  act;

      assign lane_idx[gi] = IW'(int'(beat_reg) * LANES + gi);
      assign a            = a_reg[lane_idx[gi]];
      assign b            = b_reg[lane_idx[gi]];
      assign act          = (VLW'(lane_idx[gi]) < vl_reg) && mask_reg[lane_idx[gi]];
      assign lane_val[gi] = val;

      // Element operation for this lane
      always_comb begin
        val = '0;
        if (act) begin
          case (op_reg)
            4'd0:    val = a + b;
            4'd1:    val = a - b;
            4'd2:    val = a << b[S-1:0];
            4'd3:    val = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd4:    val = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            4'd5:    val = a ^ b;
            4'd6:    val = a >> b[S-1:0];
            4'd7:    val = $signed(a) >>> b[S-1:0];
            4'd8:    val = a | b;
            4'd9:    val = a & b;
            default: val = '0;
          endcase
        end
      end
    end
  endgenerate

  // Datapath: capture on accept, fill LANES result elements per beat, hold in DONE
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      beat_reg <= '0;
      op_reg   <= '0;
      vl_reg   <= '0;
      mask_reg <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            op_reg   <= valu_op_in;
            vl_reg   <= (vl_in > VLW'(ELEMENTS)) ? VLW'(ELEMENTS) : vl_in;
            mask_reg <= mask_in;
            a_reg    <= vrs1_data_in;
            b_reg    <= vrs2_data_in;
            res_reg  <= '0;
            err_reg  <= (valu_op_in > 4'd9);
            beat_reg <= '0;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            res_reg[lane_idx[l]] <= lane_val[l];
          end
          if (!last_beat) beat_reg <= beat_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_valu_seq.sv
// Testbench for valu_seq: directed vector table, hand-written handshake/reset sequences,
// a LANES=8 instance, and randomized instructions checked against a behavioural model.
module tb_valu_seq;

  localparam int DW  = 32;
  localparam int EL  = 8;
  localparam int VLW = 4;

  typedef logic [EL-1:0][DW-1:0] vec_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [3:0] vl;
    logic [7:0] mask;
    vec_t       a;
    vec_t       b;
    vec_t       exp;
    logic       err;
  } vec_rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LANES=2 instance signals
  logic           rst_n, valid_in, ready_o, valid_o, ready_in, err;
  logic [3:0]     op;
  logic [VLW-1:0] vl;
  logic [EL-1:0]  mask;
  vec_t           vrs1, vrs2, res;

  // LANES=8 instance signals
  logic           rst_n8, valid_in8, ready_o8, valid_o8, ready_in8, err8;
  logic [3:0]     op8;
  logic [VLW-1:0] vl8;
  logic [EL-1:0]  mask8;
  vec_t           vrs18, vrs28, res8;

  valu_seq #(.DATA_WIDTH(DW), .ELEMENTS(EL), .LANES(2)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_o(ready_o),
    .valu_op_in(op), .vl_in(vl), .mask_in(mask), .vrs1_data_in(vrs1), .vrs2_data_in(vrs2),
    .valid_o(valid_o), .ready_in(ready_in), .valu_res_o(res), .err_o(err)
  );

  valu_seq #(.DATA_WIDTH(DW), .ELEMENTS(EL), .LANES(8)) u_dut8 (
    .clk_in(clk), .rst_n_in(rst_n8), .valid_in(valid_in8), .ready_o(ready_o8),
    .valu_op_in(op8), .vl_in(vl8), .mask_in(mask8), .vrs1_data_in(vrs18), .vrs2_data_in(vrs28),
    .valid_o(valid_o8), .ready_in(ready_in8), .valu_res_o(res8), .err_o(err8)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of one element, straight from the opcode definitions
  function automatic logic [31:0] ref_elem(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    int unsigned sh;
    int          sa, sb;
    sh = b % 32;
    sa = a;
    sb = b;
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return (sa < sb) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic vec_t ref_vec(input logic [3:0] o, input logic [3:0] v,
                                   input logic [7:0] m, input vec_t a, input vec_t b);
    vec_t r;
    int   eff_vl;
    eff_vl = (v > 8) ? 8 : int'(v);
    r = '0;
    for (int i = 0; i < EL; i++)
      if (i < eff_vl && m[i]) r[i] = ref_elem(o, a[i], b[i]);
    return r;
  endfunction

  // Issue one instruction on the LANES=2 instance and check latency, result and handshake
  task automatic run_instr(input string name, input logic [3:0] o, input logic [3:0] v,
                           input logic [7:0] m, input vec_t a, input vec_t b,
                           input vec_t exp, input logic exp_err, input int hold);
    int k;
    k = 0;
    while (!ready_o && k < 20) begin step(); k++; end
    check({name, " ready"}, ready_o, 1'b1);
    op = o; vl = v; mask = m; vrs1 = a; vrs2 = b; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    k = 0;
    while (!valid_o && k < 20) begin step(); k++; end
    check({name, " latency"}, k, 4);
    check({name, " res"}, res, exp);
    check({name, " err"}, err, exp_err);
    for (int h = 0; h < hold; h++) begin
      step();
      check({name, " hold res"}, {valid_o, res}, {1'b1, exp});
    end
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    check({name, " handshake"}, {valid_o, ready_o}, 2'b01);
    $display("txn %s op=%0d vl=%0d mask=%02h err=%0b", name, o, v, m, err);
  endtask

  vec_rec_t tbl[12];

  initial begin
    vec_t ra, rb, rexp;
    logic [3:0] rop, rvl;
    logic [7:0] rmask;
    int k;
    logic seen;

    // Directed vector table with hand-derived expectations
    for (int t = 0; t < 12; t++) begin
      tbl[t].vl = 4'd8; tbl[t].mask = 8'hFF; tbl[t].err = 1'b0;
      tbl[t].a = '0; tbl[t].b = '0; tbl[t].exp = '0;
    end
    tbl[0].name = "vadd_ramp";  tbl[0].op = 4'd0;
    tbl[1].name = "vsub_wrap";  tbl[1].op = 4'd1;
    tbl[2].name = "vadd_wrap";  tbl[2].op = 4'd0;
    tbl[3].name = "vsra_33";    tbl[3].op = 4'd7;
    tbl[4].name = "vslt";       tbl[4].op = 4'd3;
    tbl[5].name = "vsltu";      tbl[5].op = 4'd4;
    tbl[6].name = "vor_mask";   tbl[6].op = 4'd8; tbl[6].vl = 4'd5; tbl[6].mask = 8'b1011_0110;
    tbl[7].name = "vor_clamp";  tbl[7].op = 4'd8; tbl[7].vl = 4'd15;
    tbl[8].name = "illegal_c";  tbl[8].op = 4'hC; tbl[8].err = 1'b1;
    tbl[9].name = "vsll_wrap";  tbl[9].op = 4'd2;
    tbl[10].name = "vl_zero";   tbl[10].op = 4'd0; tbl[10].vl = 4'd0;
    tbl[11].name = "mask_zero"; tbl[11].op = 4'd0; tbl[11].mask = 8'h00;
    for (int i = 0; i < EL; i++) begin
      tbl[0].a[i] = i;            tbl[0].b[i] = 10 * i;         tbl[0].exp[i] = 11 * i;
      tbl[1].a[i] = 0;            tbl[1].b[i] = 1;              tbl[1].exp[i] = 32'hFFFF_FFFF;
      tbl[2].a[i] = 32'hFFFF_FFFF; tbl[2].b[i] = 1;             tbl[2].exp[i] = 0;
      tbl[3].a[i] = 32'h8000_0000; tbl[3].b[i] = 33;            tbl[3].exp[i] = 32'hC000_0000;
      tbl[4].a[i] = 32'hFFFF_FFFF; tbl[4].b[i] = 1;             tbl[4].exp[i] = 1;
      tbl[5].a[i] = 32'hFFFF_FFFF; tbl[5].b[i] = 1;             tbl[5].exp[i] = 0;
      tbl[6].a[i] = i << 8;       tbl[6].b[i] = i;
      tbl[6].exp[i] = (i == 1 || i == 2 || i == 4) ? 32'(i * 32'h101) : 32'd0;
      tbl[7].a[i] = i << 8;       tbl[7].b[i] = i;              tbl[7].exp[i] = i * 32'h101;
      tbl[8].a[i] = i + 1;        tbl[8].b[i] = i + 2;
      tbl[9].a[i] = 1;            tbl[9].b[i] = i + 32;         tbl[9].exp[i] = 32'd1 << i;
      tbl[10].a[i] = i + 5;       tbl[10].b[i] = 7;
      tbl[11].a[i] = i + 5;       tbl[11].b[i] = 7;
    end

    // Reset state
    rst_n = 1'b0; rst_n8 = 1'b0;
    valid_in = 1'b0; ready_in = 1'b0; op = '0; vl = '0; mask = '0; vrs1 = '0; vrs2 = '0;
    valid_in8 = 1'b0; ready_in8 = 1'b0; op8 = '0; vl8 = '0; mask8 = '0; vrs18 = '0; vrs28 = '0;
    step(); step();
    check("reset outputs", {valid_o, ready_o, err, res}, {3'b010, 256'd0});
    rst_n = 1'b1; rst_n8 = 1'b1;
    step();
    check("idle after reset", {valid_o, ready_o}, 2'b01);

    // Directed table
    for (int t = 0; t < 12; t++)
      run_instr(tbl[t].name, tbl[t].op, tbl[t].vl, tbl[t].mask, tbl[t].a, tbl[t].b,
                tbl[t].exp, tbl[t].err, 0);

    // Illegal opcode with backpressure; valid_in pulses during DONE must be ignored
    op = 4'hC; vl = 4'd8; mask = 8'hFF; vrs1 = tbl[8].a; vrs2 = tbl[8].b; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    k = 0;
    while (!valid_o && k < 20) begin step(); k++; end
    check("bp latency", k, 4);
    for (int h = 0; h < 3; h++) begin
      valid_in = 1'b1; op = 4'd0; vrs1 = tbl[0].a; vrs2 = tbl[0].b;
      step();
      check("bp hold", {valid_o, ready_o, err, res}, {3'b101, 256'd0});
    end
    valid_in = 1'b0; ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    check("bp handshake", {valid_o, ready_o}, 2'b01);
    seen = 1'b0;
    for (int h = 0; h < 8; h++) begin step(); seen |= valid_o; end
    check("bp no stray accept", {seen, ready_o, res}, {2'b01, 256'd0});
    $display("txn bp_illegal op=12 held 3 cycles");

    // Async reset during BUSY beat 2, with valid_in ignored while reset is held
    op = 4'd0; vl = 4'd8; mask = 8'hFF; vrs1 = tbl[0].a; vrs2 = tbl[0].b; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("midreset outputs", {valid_o, ready_o, err, res}, {3'b010, 256'd0});
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    rst_n = 1'b1;
    step();
    check("midreset idle", {valid_o, ready_o, res}, {2'b01, 256'd0});
    $display("txn midreset dropped");
    for (int i = 0; i < EL; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
    run_instr("vand_after_reset", 4'd9, 4'd8, 8'hFF, ra, rb, ref_vec(4'd9, 4'd8, 8'hFF, ra, rb),
              1'b0, 1);

    // LANES=8: one beat, reset during BUSY, then a full VAND
    op8 = 4'd9; vl8 = 4'd8; mask8 = 8'hFF; vrs18 = ra; vrs28 = rb; valid_in8 = 1'b1;
    step();
    valid_in8 = 1'b0;
    rst_n8 = 1'b0;
    #1;
    check("l8 midreset", {valid_o8, ready_o8, err8, res8}, {3'b010, 256'd0});
    step();
    rst_n8 = 1'b1;
    for (int i = 0; i < EL; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
    op8 = 4'd9; vl8 = 4'd8; mask8 = 8'hFF; vrs18 = ra; vrs28 = rb; valid_in8 = 1'b1;
    step();
    valid_in8 = 1'b0;
    k = 0;
    while (!valid_o8 && k < 20) begin step(); k++; end
    check("l8 latency", k, 1);
    check("l8 res", {err8, res8}, {1'b0, ref_vec(4'd9, 4'd8, 8'hFF, ra, rb)});
    ready_in8 = 1'b1;
    step();
    ready_in8 = 1'b0;
    check("l8 handshake", {valid_o8, ready_o8}, 2'b01);
    $display("txn l8_vand done");

    // Randomized instructions against the behavioural model
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      rvl = 4'($urandom_range(0, 15));
      rmask = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin rvl = 4'd8; rmask = 8'hFF; end
      for (int i = 0; i < EL; i++) begin
        ra[i] = $urandom;
        rb[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      end
      rexp = ref_vec(rop, rvl, rmask, ra, rb);
      run_instr($sformatf("rand%0d", n), rop, rvl, rmask, ra, rb, rexp, (rop > 4'd9),
                $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
